// File: rtl/branch_result_collector_pkg.sv
// rtl/branch_result_collector_pkg.sv - shared types, sizes and age helper for the branch result collector
package branch_result_collector_pkg;

    localparam int INT_ISSUE_WIDTH = 2;
    localparam int DEPTH           = 8;
    localparam int ADDR_WIDTH      = 32;
    localparam int GHR_WIDTH       = 10;
    localparam int AL_PTR_WIDTH    = 6;
    localparam int PTR_WIDTH       = $clog2(DEPTH);
    localparam int CNT_WIDTH       = PTR_WIDTH + 1;

    typedef logic [AL_PTR_WIDTH-1:0] al_ptr_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] brAddr;
        logic [ADDR_WIDTH-1:0] nextAddr;
        logic                  execTaken;
        logic                  predTaken;
        logic                  isCondBr;
        logic                  mispred;
        logic [GHR_WIDTH-1:0]  globalHistory;
        logic [1:0]            phtPrevValue;
    } br_result_entry_t;

    typedef enum logic {
        REC_IDLE,
        REC_PENDING
    } rec_state_t;

    // Distance from the active-list head; modular subtraction handles pointer wrap.
    function automatic al_ptr_t al_age(input al_ptr_t ptr, input al_ptr_t head);
        return ptr - head;
    endfunction

endpackage

// File: rtl/branch_result_collector_if.sv
// rtl/branch_result_collector_if.sv - execution-side, updater and recovery signals of the collector
interface branch_result_collector_if
    import branch_result_collector_pkg::*;
    ;

    logic [INT_ISSUE_WIDTH-1:0] in_valid;
    br_result_entry_t           in_br    [INT_ISSUE_WIDTH];
    al_ptr_t                    in_alPtr [INT_ISSUE_WIDTH];
    logic                       in_ready;
    al_ptr_t                    al_head_ptr;
    logic                       upd_valid;
    br_result_entry_t           upd_br;
    logic                       upd_ready;
    logic                       rec_valid;
    br_result_entry_t           rec_br;
    al_ptr_t                    rec_alPtr;
    logic                       rec_ack;
    logic                       overflow;

    modport master (
        output in_valid, in_br, in_alPtr, al_head_ptr, upd_ready, rec_ack,
        input  in_ready, upd_valid, upd_br, rec_valid, rec_br, rec_alPtr, overflow
    );

    modport slave (
        input  in_valid, in_br, in_alPtr, al_head_ptr, upd_ready, rec_ack,
        output in_ready, upd_valid, upd_br, rec_valid, rec_br, rec_alPtr, overflow
    );

endinterface

// File: rtl/br_result_multi_push_queue.sv
// rtl/br_result_multi_push_queue.sv - in-order queue accepting several lanes per cycle, popping one
module br_result_multi_push_queue
    import branch_result_collector_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INT_ISSUE_WIDTH-1:0] push_valid,
    input  br_result_entry_t           push_data [INT_ISSUE_WIDTH],
    input  logic                       pop,
    output logic [INT_ISSUE_WIDTH-1:0] accepted,
    output logic                       dropped,
    output logic [CNT_WIDTH-1:0]       count,
    output logic                       in_ready,
    output br_result_entry_t           head_data
);

    br_result_entry_t       mem [DEPTH];
    logic [PTR_WIDTH-1:0]   head;
    logic [PTR_WIDTH-1:0]   tail;
    logic [PTR_WIDTH-1:0]   slot [INT_ISSUE_WIDTH];
    logic [CNT_WIDTH-1:0]   free;
    logic [CNT_WIDTH-1:0]   n_enq;
    logic [CNT_WIDTH-1:0]   count_next;
    logic                   deq;

    // Fit is judged against the start-of-cycle occupancy, so a same-cycle pop never makes room.
    always_comb begin
        free     = CNT_WIDTH'(DEPTH) - count;
        n_enq    = '0;
        accepted = '0;
        dropped  = 1'b0;
        for (int i = 0; i < INT_ISSUE_WIDTH; i++) begin
            slot[i] = tail + PTR_WIDTH'(n_enq);
            if (push_valid[i]) begin
                if (n_enq < free) begin
                    accepted[i] = 1'b1;
                    n_enq       = n_enq + CNT_WIDTH'(1);
                end else begin
                    dropped = 1'b1;
                end
            end
        end
        deq        = pop && (count != '0);
        count_next = count + n_enq - CNT_WIDTH'(deq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            head     <= head + PTR_WIDTH'(deq);
            tail     <= tail + PTR_WIDTH'(n_enq);
            count    <= count_next;
            in_ready <= (CNT_WIDTH'(DEPTH) - count_next) >= CNT_WIDTH'(INT_ISSUE_WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < INT_ISSUE_WIDTH; i++) begin
            if (accepted[i]) begin
                mem[slot[i]] <= push_data[i];
            end
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/branch_result_collector.sv
// rtl/branch_result_collector.sv - queues branch results for predictor update and holds the oldest misprediction
module branch_result_collector
    import branch_result_collector_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    branch_result_collector_if.slave  bus
);

    logic [INT_ISSUE_WIDTH-1:0] accepted;
    logic                       dropped;
    logic [CNT_WIDTH-1:0]       count;
    logic                       q_in_ready;
    br_result_entry_t           head_data;

    br_result_multi_push_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_valid (bus.in_valid),
        .push_data  (bus.in_br),
        .pop        (bus.upd_ready),
        .accepted   (accepted),
        .dropped    (dropped),
        .count      (count),
        .in_ready   (q_in_ready),
        .head_data  (head_data)
    );

    assign bus.in_ready  = q_in_ready;
    assign bus.upd_valid = (count != '0);
    assign bus.upd_br    = head_data;

    rec_state_t       state;
    logic             rec_valid;
    br_result_entry_t rec_br;
    al_ptr_t          rec_ptr;
    logic             overflow;
    logic             cand_valid;
    br_result_entry_t cand_br;
    al_ptr_t          cand_ptr;
    logic             cand_older;

    // Only lanes that actually made it into the queue compete; strict compare keeps the lower lane on equal age.
    always_comb begin
        cand_valid = 1'b0;
        cand_br    = '0;
        cand_ptr   = '0;
        for (int i = 0; i < INT_ISSUE_WIDTH; i++) begin
            if (accepted[i] && bus.in_br[i].mispred &&
                (!cand_valid || al_age(bus.in_alPtr[i], bus.al_head_ptr) < al_age(cand_ptr, bus.al_head_ptr))) begin
                cand_valid = 1'b1;
                cand_br    = bus.in_br[i];
                cand_ptr   = bus.in_alPtr[i];
            end
        end
        cand_older = al_age(cand_ptr, bus.al_head_ptr) < al_age(rec_ptr, bus.al_head_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= REC_IDLE;
            rec_valid <= 1'b0;
            rec_br    <= '0;
            rec_ptr   <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= overflow | dropped;
            case (state)
                REC_IDLE: begin
                    if (cand_valid) begin
                        state     <= REC_PENDING;
                        rec_valid <= 1'b1;
                        rec_br    <= cand_br;
                        rec_ptr   <= cand_ptr;
                    end
                end
                REC_PENDING: begin
                    if (bus.rec_ack) begin
                        if (cand_valid) begin
                            rec_br  <= cand_br;
                            rec_ptr <= cand_ptr;
                        end else begin
                            state     <= REC_IDLE;
                            rec_valid <= 1'b0;
                        end
                    end else if (cand_valid && cand_older) begin
                        rec_br  <= cand_br;
                        rec_ptr <= cand_ptr;
                    end
                end
                default: begin
                    state     <= REC_IDLE;
                    rec_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rec_valid = rec_valid;
    assign bus.rec_br    = rec_br;
    assign bus.rec_alPtr = rec_ptr;
    assign bus.overflow  = overflow;

endmodule

// File: tb/tb_branch_result_collector.sv
// tb/tb_branch_result_collector.sv - scoreboard bench for branch_result_collector
module tb_branch_result_collector;
    import branch_result_collector_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    br_result_entry_t exp_q [$];
    br_result_entry_t mon_exp;

    branch_result_collector_if bus ();

    branch_result_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic br_result_entry_t mk(input logic [31:0] a, input logic mp);
        br_result_entry_t e;
        e.brAddr        = a;
        e.nextAddr      = a + 32'h40;
        e.execTaken     = a[2];
        e.predTaken     = a[2] ^ mp;
        e.isCondBr      = 1'b1;
        e.mispred       = mp;
        e.globalHistory = a[11:2];
        e.phtPrevValue  = a[3:2];
        return e;
    endfunction

    task automatic present(input logic [1:0] v, input br_result_entry_t e0, input br_result_entry_t e1,
                           input al_ptr_t p0, input al_ptr_t p1, input logic [1:0] fit);
        bus.in_valid    = v;
        bus.in_br[0]    = e0;
        bus.in_br[1]    = e1;
        bus.in_alPtr[0] = p0;
        bus.in_alPtr[1] = p1;
        if (v[0] && fit[0]) exp_q.push_back(e0);
        if (v[1] && fit[1]) exp_q.push_back(e1);
        tick();
        bus.in_valid = '0;
    endtask

    task automatic drain(input string name);
        bus.upd_ready = 1'b1;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
        tick();
        chk({name, "_drained"}, 128'(exp_q.size()), 128'(0));
        chk({name, "_upd_valid_empty"}, 128'(bus.upd_valid), 128'(0));
    endtask

    // Monitor: every accepted head entry must match the next expected entry in issue order.
    always @(negedge clk) begin
        if (!rst && bus.upd_valid && bus.upd_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL upd_unexpected: got %0h expected none", bus.upd_br.brAddr);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("upd_br", 128'(bus.upd_br), 128'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int guard;
        logic [1:0] m;
        bus.in_valid    = '0;
        bus.in_br[0]    = '0;
        bus.in_br[1]    = '0;
        bus.in_alPtr[0] = '0;
        bus.in_alPtr[1] = '0;
        bus.al_head_ptr = '0;
        bus.upd_ready   = 1'b0;
        bus.rec_ack     = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("reset_in_ready",  128'(bus.in_ready), 128'(1));
        chk("reset_upd_valid", 128'(bus.upd_valid), 128'(0));
        chk("reset_rec_valid", 128'(bus.rec_valid), 128'(0));
        chk("reset_rec_br",    128'(bus.rec_br), 128'(0));
        chk("reset_rec_alPtr", 128'(bus.rec_alPtr), 128'(0));
        chk("reset_overflow",  128'(bus.overflow), 128'(0));

        // Dual push drains in lane order, one per cycle.
        bus.upd_ready = 1'b1;
        present(2'b11, mk(32'h100, 1'b0), mk(32'h104, 1'b0), 6'd0, 6'd1, 2'b11);
        chk("dual_upd_valid_latency", 128'(bus.upd_valid), 128'(1));
        chk("dual_first_head", 128'(bus.upd_br.brAddr), 128'(32'h100));
        tick();
        chk("dual_second_head", 128'(bus.upd_br.brAddr), 128'(32'h104));
        tick();
        chk("dual_empty", 128'(bus.upd_valid), 128'(0));

        // Fill with the updater stalled, then overrun by one dual push.
        bus.upd_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            present(2'b11, mk(32'h200 + 8*i, 1'b0), mk(32'h204 + 8*i, 1'b0), 6'd0, 6'd0, 2'b11);
        chk("fill3_in_ready", 128'(bus.in_ready), 128'(1));
        present(2'b11, mk(32'h218, 1'b0), mk(32'h21c, 1'b0), 6'd0, 6'd0, 2'b11);
        chk("fill4_in_ready", 128'(bus.in_ready), 128'(0));
        chk("fill4_overflow", 128'(bus.overflow), 128'(0));
        present(2'b11, mk(32'h220, 1'b1), mk(32'h224, 1'b0), 6'd3, 6'd4, 2'b00);
        chk("fill5_overflow", 128'(bus.overflow), 128'(1));
        chk("dropped_no_recovery", 128'(bus.rec_valid), 128'(0));
        drain("fill");
        chk("fill_in_ready_after", 128'(bus.in_ready), 128'(1));
        chk("overflow_sticky", 128'(bus.overflow), 128'(1));

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_clears_overflow", 128'(bus.overflow), 128'(0));

        // Recovery selection with head at 60.
        bus.al_head_ptr = 6'd60;
        bus.upd_ready   = 1'b1;
        present(2'b11, mk(32'h300, 1'b1), mk(32'h304, 1'b1), 6'd2, 6'd62, 2'b11);
        chk("rec_first_valid", 128'(bus.rec_valid), 128'(1));
        chk("rec_first_ptr",   128'(bus.rec_alPtr), 128'(62));
        chk("rec_first_addr",  128'(bus.rec_br.brAddr), 128'(32'h304));
        present(2'b01, mk(32'h308, 1'b1), mk(32'h0, 1'b0), 6'd61, 6'd0, 2'b11);
        chk("rec_older_ptr",  128'(bus.rec_alPtr), 128'(61));
        chk("rec_older_addr", 128'(bus.rec_br.brAddr), 128'(32'h308));
        present(2'b10, mk(32'h0, 1'b0), mk(32'h30c, 1'b1), 6'd0, 6'd63, 2'b11);
        chk("rec_younger_hold", 128'(bus.rec_alPtr), 128'(61));
        tick();
        chk("rec_idle_hold", 128'(bus.rec_br.brAddr), 128'(32'h308));
        bus.rec_ack = 1'b1;
        present(2'b10, mk(32'h0, 1'b0), mk(32'h310, 1'b1), 6'd0, 6'd1, 2'b11);
        chk("rec_ack_new_valid", 128'(bus.rec_valid), 128'(1));
        chk("rec_ack_new_ptr",   128'(bus.rec_alPtr), 128'(1));
        chk("rec_ack_new_addr",  128'(bus.rec_br.brAddr), 128'(32'h310));
        tick();
        bus.rec_ack = 1'b0;
        chk("rec_ack_clear", 128'(bus.rec_valid), 128'(0));
        present(2'b01, mk(32'h314, 1'b0), mk(32'h0, 1'b0), 6'd60, 6'd0, 2'b11);
        chk("no_mispred_no_rec", 128'(bus.rec_valid), 128'(0));
        drain("rec");

        // Stream 20 entries through the 8-deep queue with a toggling updater.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        sent  = 0;
        guard = 0;
        while (sent < 20 && guard < 200) begin
            guard++;
            bus.upd_ready = guard[0];
            if (bus.in_ready) begin
                m = (guard % 3 == 0) ? 2'b10 : 2'b11;
                present(m, mk(32'h1000 + 4*sent, 1'b0), mk(32'h1000 + 4*(sent + (m[0] ? 1 : 0)), 1'b0),
                        6'd0, 6'd0, 2'b11);
                sent += m[0] ? 2 : 1;
            end else begin
                tick();
            end
        end
        chk("stream_sent", 128'(sent >= 20), 128'(1));
        drain("stream");
        chk("stream_overflow", 128'(bus.overflow), 128'(0));
        chk("stream_rec_valid", 128'(bus.rec_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
